ftdi_fifo_responder: RTL and testbench



---
 rtl/ftdi_pkg.sv | 33 +++
 rtl/byte_fifo.sv | 67 ++++++
 rtl/ftdi_fifo_responder.sv | 195 +++++++++++++++++++
 tb/tb_ftdi_fifo_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ftdi_pkg.sv
// ftdi_pkg: shared types and defaults for the FTDI 245-FIFO bus responder.
//   ftdi_state_e       : responder bus FSM states
//   ftdi_byte_t        : one bus / FIFO byte
//   FTDI_DEPTH_DEF     : default byte FIFO depth
//   FTDI_RD_TURN_DEF   : default RXF# hold-off after RD# rises
//   FTDI_WR_TURN_DEF   : default TXE# hold-off after WR# rises
package ftdi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_RD_ACTIVE  = 3'd1,
      ST_RD_RECOVER = 3'd2,
      ST_WR_ACTIVE  = 3'd3,
      ST_WR_RECOVER = 3'd4
   } ftdi_state_e;

   typedef logic [7:0] ftdi_byte_t;

   localparam int FTDI_DEPTH_DEF   = 16;
   localparam int FTDI_RD_TURN_DEF = 2;
   localparam int FTDI_WR_TURN_DEF = 2;

   // True for the read-side states, used by the strobe-overlap checker.
   function automatic logic is_rd_state(input ftdi_state_e st);
      return (st == ST_RD_ACTIVE) || (st == ST_RD_RECOVER);
   endfunction

   // True for the write-side states, used by the strobe-overlap checker.
   function automatic logic is_wr_state(input ftdi_state_e st);
      return (st == ST_WR_ACTIVE) || (st == ST_WR_RECOVER);
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous byte FIFO with registered count, no same-cycle bypass.
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   push_i/push_data_i : push request and byte; accepted when push_ready_o
//   push_ready_o       : not full (forced 0 during reset)
//   pop_i              : pop request; performed when pop_valid_o
//   pop_data_o         : head byte
//   pop_valid_o        : not empty (forced 0 during reset)
module byte_fifo
   import ftdi_pkg::*;
#(
   parameter int DEPTH = FTDI_DEPTH_DEF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       push_i,
   input  ftdi_byte_t push_data_i,
   output logic       push_ready_o,
   input  logic       pop_i,
   output ftdi_byte_t pop_data_o,
   output logic       pop_valid_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   ftdi_byte_t       mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             push_fire_s;
   logic             pop_fire_s;

   assign push_ready_o = !reset && (count_q != CW'(DEPTH));
   assign pop_valid_o  = !reset && (count_q != {CW{1'b0}});
   assign push_fire_s  = push_i && push_ready_o;
   assign pop_fire_s   = pop_i && pop_valid_o;
   assign pop_data_o   = mem_q[rd_ptr_q];

   // Storage array; contents need no reset because the count gates visibility.
   always_ff @(posedge clock) begin
      if (push_fire_s) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   // Pointers wrap naturally at DEPTH (power of two); simultaneous push/pop keeps count.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         if (push_fire_s) begin
            wr_ptr_q <= wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
         end
         if (pop_fire_s) begin
            rd_ptr_q <= rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
         end
         case ({push_fire_s, pop_fire_s})
            2'b10:   count_q <= count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_q <= count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/ftdi_fifo_responder.sv
// ftdi_fifo_responder: FTDI-side partner for the asynchronous 245 FIFO bus.
// Host bytes queue in the RX FIFO and are offered via RXF#/RD#; FPGA bytes are
// accepted via TXE#/WR# into the TX FIFO for the host to drain.
//   clock, reset                 : rising-edge clock, synchronous active-high reset
//   rd, wr                       : RD#, WR# from the FPGA (active low)
//   adbus_in                     : bus value driven by the FPGA
//   rxf, txe                     : RXF#, TXE# (active low, registered)
//   adbus_out, adbus_oe          : byte toward the FPGA and its drive enable
//   host_wr_data/valid/ready     : host push into the RX FIFO
//   host_rd_data/valid/ready     : host pop from the TX FIFO
//   proto_err                    : sticky protocol-violation flag
// Build option: define FTDI_RESP_CHECK_EN to enable the protocol checker;
// without it proto_err is tied low.
module ftdi_fifo_responder
   import ftdi_pkg::*;
#(
   parameter int DEPTH         = FTDI_DEPTH_DEF,
   parameter int RD_TURNAROUND = FTDI_RD_TURN_DEF,
   parameter int WR_TURNAROUND = FTDI_WR_TURN_DEF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rd,
   input  logic       wr,
   input  ftdi_byte_t adbus_in,
   output logic       rxf,
   output logic       txe,
   output ftdi_byte_t adbus_out,
   output logic       adbus_oe,
   input  ftdi_byte_t host_wr_data,
   input  logic       host_wr_valid,
   output logic       host_wr_ready,
   output ftdi_byte_t host_rd_data,
   output logic       host_rd_valid,
   input  logic       host_rd_ready,
   output logic       proto_err
);

   ftdi_state_e state_q;
   logic        rxf_q;
   logic        txe_q;
   logic        adbus_oe_q;
   ftdi_byte_t  adbus_out_q;
   ftdi_byte_t  hold_q;
   logic [7:0]  turn_q;

   ftdi_byte_t  rx_head_s;
   logic        rx_valid_s;
   logic        tx_ready_s;
   logic        rx_pop_s;
   logic        tx_push_s;

   // The RX pop and TX push happen on the strobe-release edge itself.
   assign rx_pop_s  = (state_q == ST_RD_ACTIVE) && rd;
   assign tx_push_s = (state_q == ST_WR_ACTIVE) && wr;

   byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
      .clock       (clock),
      .reset       (reset),
      .push_i      (host_wr_valid),
      .push_data_i (host_wr_data),
      .push_ready_o(host_wr_ready),
      .pop_i       (rx_pop_s),
      .pop_data_o  (rx_head_s),
      .pop_valid_o (rx_valid_s)
   );

   byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
      .clock       (clock),
      .reset       (reset),
      .push_i      (tx_push_s),
      .push_data_i (hold_q),
      .push_ready_o(tx_ready_s),
      .pop_i       (host_rd_ready),
      .pop_data_o  (host_rd_data),
      .pop_valid_o (host_rd_valid)
   );

   // Bus FSM with registered strobes; read wins when RD# and WR# arrive together.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         rxf_q       <= 1'b1;
         txe_q       <= 1'b1;
         adbus_oe_q  <= 1'b0;
         adbus_out_q <= 8'h00;
         hold_q      <= 8'h00;
         turn_q      <= 8'h00;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!rd && !rxf_q) begin
                  state_q     <= ST_RD_ACTIVE;
                  adbus_oe_q  <= 1'b1;
                  adbus_out_q <= rx_head_s;
                  rxf_q       <= 1'b0;
                  txe_q       <= 1'b1;
               end else if (!wr && !txe_q) begin
                  state_q <= ST_WR_ACTIVE;
                  hold_q  <= adbus_in;
                  rxf_q   <= 1'b1;
                  txe_q   <= 1'b1;
               end else begin
                  rxf_q <= !rx_valid_s;
                  txe_q <= !tx_ready_s;
               end
            end
            ST_RD_ACTIVE: begin
               if (rd) begin
                  state_q    <= ST_RD_RECOVER;
                  adbus_oe_q <= 1'b0;
                  rxf_q      <= 1'b1;
                  turn_q     <= 8'(RD_TURNAROUND - 1);
               end else begin
                  state_q <= ST_RD_ACTIVE;
               end
            end
            ST_WR_ACTIVE: begin
               if (wr) begin
                  state_q <= ST_WR_RECOVER;
                  turn_q  <= 8'(WR_TURNAROUND - 1);
               end else begin
                  hold_q <= adbus_in;
               end
            end
            ST_RD_RECOVER, ST_WR_RECOVER: begin
               // Strobes are re-evaluated from the FIFO state on the return edge.
               if (turn_q == 8'h00) begin
                  state_q <= ST_IDLE;
                  rxf_q   <= !rx_valid_s;
                  txe_q   <= !tx_ready_s;
               end else begin
                  turn_q <= turn_q - 8'h01;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               adbus_oe_q <= 1'b0;
               rxf_q      <= 1'b1;
               txe_q      <= 1'b1;
            end
         endcase
      end
   end

   assign rxf       = rxf_q;
   assign txe       = txe_q;
   assign adbus_oe  = adbus_oe_q;
   assign adbus_out = adbus_out_q;

`ifdef FTDI_RESP_CHECK_EN
   logic       proto_err_q;
   ftdi_byte_t adbus_in_prev_q;
   logic       both_low_s;
   logic       rd_in_wr_s;
   logic       wr_in_rd_s;
   logic       contention_s;

   // Classify each violation separately so the assertions can name them.
   always_comb begin
      both_low_s   = !rd && !wr;
      rd_in_wr_s   = !rd && is_wr_state(state_q);
      wr_in_rd_s   = !wr && is_rd_state(state_q);
      contention_s = adbus_oe_q && (adbus_in != adbus_in_prev_q);
   end

   // Sticky error flag plus the previous bus value for contention detection.
   always_ff @(posedge clock) begin
      if (reset) begin
         proto_err_q     <= 1'b0;
         adbus_in_prev_q <= 8'h00;
      end else begin
         proto_err_q     <= proto_err_q | both_low_s | rd_in_wr_s | wr_in_rd_s | contention_s;
         adbus_in_prev_q <= adbus_in;
      end
   end

   assign proto_err = proto_err_q;

`ifndef SYNTHESIS
   // Simulation-only notices on each protocol violation.
   always @(posedge clock) begin
      if (!reset) begin
         assert (!both_low_s)   else $warning("ftdi: RD# and WR# low together");
         assert (!rd_in_wr_s)   else $warning("ftdi: RD# low during write cycle");
         assert (!wr_in_rd_s)   else $warning("ftdi: WR# low during read cycle");
         assert (!contention_s) else $warning("ftdi: bus contention on ADBUS");
      end
   end
`endif
`else
   assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_ftdi_fifo_responder.sv
// tb_ftdi_fifo_responder: directed self-checking bench for ftdi_fifo_responder.
module tb_ftdi_fifo_responder;
   import ftdi_pkg::*;

   logic       clock;
   logic       reset;
   logic       rd;
   logic       wr;
   ftdi_byte_t adbus_in;
   logic       rxf;
   logic       txe;
   ftdi_byte_t adbus_out;
   logic       adbus_oe;
   ftdi_byte_t host_wr_data;
   logic       host_wr_valid;
   logic       host_wr_ready;
   ftdi_byte_t host_rd_data;
   logic       host_rd_valid;
   logic       host_rd_ready;
   logic       proto_err;

   int n_checks;
   int n_pass;

   ftdi_fifo_responder #(.DEPTH(16), .RD_TURNAROUND(2), .WR_TURNAROUND(2)) dut (
      .clock        (clock),
      .reset        (reset),
      .rd           (rd),
      .wr           (wr),
      .adbus_in     (adbus_in),
      .rxf          (rxf),
      .txe          (txe),
      .adbus_out    (adbus_out),
      .adbus_oe     (adbus_oe),
      .host_wr_data (host_wr_data),
      .host_wr_valid(host_wr_valid),
      .host_wr_ready(host_wr_ready),
      .host_rd_data (host_rd_data),
      .host_rd_valid(host_rd_valid),
      .host_rd_ready(host_rd_ready),
      .proto_err    (proto_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge, then settle 1 time unit past it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic host_push(input ftdi_byte_t b);
      host_wr_data  = b;
      host_wr_valid = 1'b1;
      tick();
      host_wr_valid = 1'b0;
   endtask

   task automatic wait_rxf_low(input string tag);
      for (int k = 0; k < 20 && rxf !== 1'b0; k++) tick();
      check(tag, {31'd0, rxf}, 32'd0);
   endtask

   task automatic wait_txe_low(input string tag);
      for (int k = 0; k < 20 && txe !== 1'b0; k++) tick();
      check(tag, {31'd0, txe}, 32'd0);
   endtask

   // One full RD# cycle: wait for RXF#, strobe, check the byte, release.
   task automatic bus_read(input ftdi_byte_t exp, input string tag);
      wait_rxf_low({tag, "_rxf"});
      rd = 1'b0;
      tick();
      check({tag, "_oe"}, {31'd0, adbus_oe}, 32'd1);
      check({tag, "_data"}, {24'd0, adbus_out}, {24'd0, exp});
      rd = 1'b1;
      tick();
   endtask

   initial begin
      n_checks      = 0;
      n_pass        = 0;
      reset         = 1'b1;
      rd            = 1'b1;
      wr            = 1'b1;
      adbus_in      = 8'h00;
      host_wr_data  = 8'h00;
      host_wr_valid = 1'b0;
      host_rd_ready = 1'b0;
      repeat (3) tick();

      // Reset state
      check("rst_rxf", {31'd0, rxf}, 32'd1);
      check("rst_txe", {31'd0, txe}, 32'd1);
      check("rst_oe", {31'd0, adbus_oe}, 32'd0);
      check("rst_out", {24'd0, adbus_out}, 32'd0);
      check("rst_perr", {31'd0, proto_err}, 32'd0);
      check("rst_wready", {31'd0, host_wr_ready}, 32'd0);
      check("rst_rvalid", {31'd0, host_rd_valid}, 32'd0);
      reset = 1'b0;
      tick();
      check("post_rst_txe", {31'd0, txe}, 32'd0);
      check("post_rst_wready", {31'd0, host_wr_ready}, 32'd1);

      // Single host byte out over RD#
      host_push(8'hA5);
      check("push_rxf_c1", {31'd0, rxf}, 32'd1);
      tick();
      check("push_rxf_c2", {31'd0, rxf}, 32'd0);
      rd = 1'b0;
      tick();
      check("rd_oe", {31'd0, adbus_oe}, 32'd1);
      check("rd_data", {24'd0, adbus_out}, 32'hA5);
      check("rd_rxf_hold", {31'd0, rxf}, 32'd0);
      check("rd_txe_busy", {31'd0, txe}, 32'd1);
      tick();
      check("rd_oe_hold", {31'd0, adbus_oe}, 32'd1);
      rd = 1'b1;
      tick();
      check("rdrel_oe", {31'd0, adbus_oe}, 32'd0);
      check("rdrel_rxf0", {31'd0, rxf}, 32'd1);
      tick();
      check("rdrel_rxf1", {31'd0, rxf}, 32'd1);
      tick();
      check("rdrel_rxf2", {31'd0, rxf}, 32'd1);
      check("rdrel_txe", {31'd0, txe}, 32'd0);
      repeat (2) tick();
      check("rd_empty_rxf", {31'd0, rxf}, 32'd1);

      // 3-cycle WR# pulse; the byte from the last low cycle is kept
      wr = 1'b0;
      adbus_in = 8'h11;
      tick();
      check("wr_txe_c0", {31'd0, txe}, 32'd1);
      adbus_in = 8'h22;
      tick();
      check("wr_txe_c1", {31'd0, txe}, 32'd1);
      adbus_in = 8'h3C;
      tick();
      check("wr_txe_c2", {31'd0, txe}, 32'd1);
      check("wr_not_yet", {31'd0, host_rd_valid}, 32'd0);
      wr = 1'b1;
      adbus_in = 8'hFF;
      tick();
      check("wr_rvalid", {31'd0, host_rd_valid}, 32'd1);
      check("wr_rdata", {24'd0, host_rd_data}, 32'h3C);
      check("wr_txe_c3", {31'd0, txe}, 32'd1);
      tick();
      check("wr_txe_c4", {31'd0, txe}, 32'd1);
      tick();
      check("wr_txe_back", {31'd0, txe}, 32'd0);
      host_rd_ready = 1'b1;
      tick();
      host_rd_ready = 1'b0;
      check("tx_drained", {31'd0, host_rd_valid}, 32'd0);

      // Fill/drain RX twice; pointers start at 1, so both passes wrap
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 16; i++) begin
            if (i == 15) check("fill_ready15", {31'd0, host_wr_ready}, 32'd1);
            host_push(8'(pass * 16 + i));
         end
         check("fill_full", {31'd0, host_wr_ready}, 32'd0);
         for (int i = 0; i < 16; i++) begin
            bus_read(8'(pass * 16 + i), "drain");
         end
         repeat (3) tick();
         check("drain_empty", {31'd0, rxf}, 32'd1);
      end

      // RD# and WR# together: read wins, no TX push
      host_push(8'h5A);
      wait_rxf_low("both_rxf");
      check("both_txe", {31'd0, txe}, 32'd0);
      adbus_in = 8'h77;
      rd = 1'b0;
      wr = 1'b0;
      tick();
      check("both_oe", {31'd0, adbus_oe}, 32'd1);
      check("both_data", {24'd0, adbus_out}, 32'h5A);
`ifdef FTDI_RESP_CHECK_EN
      check("both_perr", {31'd0, proto_err}, 32'd1);
`else
      check("both_perr", {31'd0, proto_err}, 32'd0);
`endif
      rd = 1'b1;
      wr = 1'b1;
      repeat (4) tick();
      check("both_no_push", {31'd0, host_rd_valid}, 32'd0);

      // Reset in the middle of a read with 5 RX bytes and 1 TX byte queued
      wait_txe_low("pre_rst_txe");
      wr = 1'b0;
      adbus_in = 8'h99;
      tick();
      wr = 1'b1;
      tick();
      check("pre_rst_rvalid", {31'd0, host_rd_valid}, 32'd1);
      for (int i = 0; i < 5; i++) host_push(8'hC0 + 8'(i));
      wait_rxf_low("mid_rxf");
      rd = 1'b0;
      tick();
      check("mid_oe", {31'd0, adbus_oe}, 32'd1);
      reset = 1'b1;
      tick();
      check("mid_rst_oe", {31'd0, adbus_oe}, 32'd0);
      check("mid_rst_rxf", {31'd0, rxf}, 32'd1);
      check("mid_rst_rvalid", {31'd0, host_rd_valid}, 32'd0);
      check("mid_rst_wready", {31'd0, host_wr_ready}, 32'd0);
      reset = 1'b0;
      rd = 1'b1;
      tick();
      check("after_rst_txe", {31'd0, txe}, 32'd0);
      check("after_rst_perr", {31'd0, proto_err}, 32'd0);
      repeat (3) tick();
      check("after_rst_rxf", {31'd0, rxf}, 32'd1);
      check("after_rst_rvalid", {31'd0, host_rd_valid}, 32'd0);

      // RD# low while empty is ignored
      rd = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("idle_rd_oe", {31'd0, adbus_oe}, 32'd0);
         check("idle_rd_txe", {31'd0, txe}, 32'd0);
      end
      rd = 1'b1;
      host_push(8'h42);
      bus_read(8'h42, "after_ignore");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
